// File: rtl/img_pkg.sv
// Shared image-pipeline package: default geometry and counter sizing.
package img_pkg;

  localparam int DEF_DATA_W     = 24;
  localparam int DEF_PIC_WIDTH  = 250;
  localparam int DEF_PIC_HEIGHT = 250;

  // Bits needed for a counter running 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/line_buffer_3row_if.sv
// Pixel stream bundle: raster input side plus the three aligned row taps.
interface line_buffer_3row_if #(
  parameter int DATA_W = img_pkg::DEF_DATA_W
);
  logic              sof;
  logic              valid_in;
  logic [DATA_W-1:0] din;
  logic              valid_out;
  logic [DATA_W-1:0] dout1;
  logic [DATA_W-1:0] dout2;
  logic [DATA_W-1:0] dout3;
  logic              eol_out;
  logic              eof_out;

  modport master (
    output sof, valid_in, din,
    input  valid_out, dout1, dout2, dout3, eol_out, eof_out
  );

  modport slave (
    input  sof, valid_in, din,
    output valid_out, dout1, dout2, dout3, eol_out, eof_out
  );
endinterface

// File: rtl/line_buffer_3row_line_ram.sv
// One line of pixel storage. The read port returns the contents held before
// this cycle's write, so a single address serves both the read and the write.
module line_ram #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 250,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Store the accepted pixel; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer feeding the 3x3 morphology window. Two cascaded line
// memories supply the pixels one and two rows above the current column.
module line_buffer_3row
  import img_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
  parameter int PIC_HEIGHT = DEF_PIC_HEIGHT
) (
  input logic              clk,
  input logic              rst_n,
  line_buffer_3row_if.slave bus
);

  localparam int CW = cnt_width(PIC_WIDTH);
  localparam int RW = cnt_width(PIC_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

  logic [CW-1:0]     col_r, cur_col_s, col_nxt_s;
  logic [RW-1:0]     row_r, cur_row_s, row_nxt_s;
  logic              last_col_s, last_row_s, row_ge2_s;
  logic [DATA_W-1:0] rd0_s, rd1_s;
  logic [DATA_W-1:0] dout1_r, dout2_r, dout3_r;
  logic              valid_out_r, eol_out_r, eof_out_r;

  // Position of the pixel on the bus; sof forces it to the frame origin.
  always_comb begin
    cur_col_s = col_r;
    cur_row_s = row_r;
    if (bus.sof) begin
      cur_col_s = {CW{1'b0}};
      cur_row_s = {RW{1'b0}};
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    last_col_s = (cur_col_s == COL_LAST);
    last_row_s = (cur_row_s == ROW_LAST);
    row_ge2_s  = (32'(cur_row_s) >= 32'd2);
  end

  // Raster position following the pixel on the bus.
  always_comb begin
    col_nxt_s = cur_col_s + CW'(1'b1);
    row_nxt_s = cur_row_s;
    if (last_col_s) begin
      col_nxt_s = {CW{1'b0}};
      if (last_row_s) begin
        row_nxt_s = {RW{1'b0}};
      end else begin
        row_nxt_s = cur_row_s + RW'(1'b1);
      end
    end else begin
      col_nxt_s = cur_col_s + CW'(1'b1);
      row_nxt_s = cur_row_s;
    end
  end

  // mem0 holds the previous row; its old contents cascade into mem1.
  line_ram #(.DATA_W(DATA_W), .DEPTH(PIC_WIDTH), .AW(CW)) u_mem0 (
    .clk  (clk),
    .we   (bus.valid_in),
    .addr (cur_col_s),
    .wdata(bus.din),
    .rdata(rd0_s)
  );

  line_ram #(.DATA_W(DATA_W), .DEPTH(PIC_WIDTH), .AW(CW)) u_mem1 (
    .clk  (clk),
    .we   (bus.valid_in),
    .addr (cur_col_s),
    .wdata(rd0_s),
    .rdata(rd1_s)
  );

  // Counters and output taps; data taps hold across gaps, qualifiers drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r       <= {CW{1'b0}};
      row_r       <= {RW{1'b0}};
      dout1_r     <= {DATA_W{1'b0}};
      dout2_r     <= {DATA_W{1'b0}};
      dout3_r     <= {DATA_W{1'b0}};
      valid_out_r <= 1'b0;
      eol_out_r   <= 1'b0;
      eof_out_r   <= 1'b0;
    end else if (bus.valid_in) begin
      col_r       <= col_nxt_s;
      row_r       <= row_nxt_s;
      dout1_r     <= rd1_s;
      dout2_r     <= rd0_s;
      dout3_r     <= bus.din;
      valid_out_r <= row_ge2_s;
      eol_out_r   <= last_col_s;
      eof_out_r   <= last_col_s & last_row_s;
    end else begin
      valid_out_r <= 1'b0;
      eol_out_r   <= 1'b0;
      eof_out_r   <= 1'b0;
      if (bus.sof) begin
        col_r <= {CW{1'b0}};
        row_r <= {RW{1'b0}};
      end
    end
  end

  assign bus.valid_out = valid_out_r;
  assign bus.eol_out   = eol_out_r;
  assign bus.eof_out   = eof_out_r;
  assign bus.dout1     = dout1_r;
  assign bus.dout2     = dout2_r;
  assign bus.dout3     = dout3_r;

endmodule

// File: doc/line_buffer_3row.md
Name: line_buffer_3row

Overview:
- Upstream neighbour of the 3x3 morphological window stage (erode/dilate).
- Converts a raster pixel stream into three column-aligned row taps (two rows above, one row above, current row), emitted one pixel per valid cycle.
- Two on-chip line memories of PIC_WIDTH entries each, cascaded. Tolerates gaps in valid_in, frame restart and reset.

Parameters:
- DATA_W, 24, pixel width in bits (RGB888 or replicated binary).
- PIC_WIDTH, 250, pixels per line.
- PIC_HEIGHT, 250, lines per frame.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sof  in  1  start-of-frame pulse; synchronous restart of counters.
- valid_in  in  1  din valid this cycle.
- din  in  DATA_W  input pixel, raster order.
- valid_out  out  1  dout1..dout3 valid (row index of the source pixel >= 2).
- dout1  out  DATA_W  pixel at (row-2, col).
- dout2  out  DATA_W  pixel at (row-1, col).
- dout3  out  DATA_W  pixel at (row, col), i.e. delayed din.
- eol_out  out  1  qualifies the last column of a line, aligned with the outputs.
- eof_out  out  1  qualifies the last pixel of a frame, aligned with the outputs.

Behaviour:
- Reset values: all outputs 0; col, row counters 0. Line memory contents are not reset and are undefined.
- Counters:
  - col counts 0..PIC_WIDTH-1 on each accepted pixel. At PIC_WIDTH-1 it wraps to 0 and row increments.
  - row counts 0..PIC_HEIGHT-1. At (PIC_HEIGHT-1, PIC_WIDTH-1) both wrap to 0.
- Per accepted pixel (valid_in=1, same cycle):
  - read mem0[col] and mem1[col];
  - write mem0[col] <= din and mem1[col] <= old mem0[col] (read-before-write).
- Outputs: registered, latency exactly 1 cycle from valid_in.
  - dout3 = din, dout2 = old mem0[col], dout1 = old mem1[col].
  - valid_out = valid_in && (row >= 2), registered.
  - eol_out = valid_in && col==PIC_WIDTH-1, registered.
  - eof_out = eol_out condition && row==PIC_HEIGHT-1, registered.
- valid_in=0:
  - counters and memories hold;
  - valid_out, eol_out, eof_out go 0 next cycle;
  - dout1..3 hold their last values.
- sof:
  - sof=1, valid_in=0: col, row <= 0.
  - sof=1, valid_in=1: the current pixel is treated as (row 0, col 0); counters become col=1, row=0.
  - Memories are not cleared, so rows 0-1 of the new frame produce no valid_out.
- Mid-frame sof (frame aborted): the same restart; no residual valid_out from the old frame beyond the already-registered cycle.
- PIC_WIDTH==1 is not supported. PIC_HEIGHT<3 yields no valid_out.
- Throughput: 1 pixel per clock, no back-pressure. The downstream stage must accept every valid_out.
- Counter widths are $clog2 of PIC_WIDTH and PIC_HEIGHT, minimum 1 bit. Comparisons are unsigned.
- Asynchronous reset mid-frame:
  - outputs and counters return to 0 immediately;
  - the next pixel after release is treated as (0,0).

Decomposition:
- Shared package img_pkg:
  - default DATA_W, PIC_WIDTH, PIC_HEIGHT constants;
  - a function returning the counter width, at least 1.
  The erode/dilate stages use the same package.
- One sub-module, line_ram: single-port read-before-write synchronous RAM, depth PIC_WIDTH, width DATA_W, no reset. Instantiated twice (mem0, mem1).
- Counters and output registers stay in the top level.

Test Plan:
All scenarios use PIC_WIDTH=4, PIC_HEIGHT=4, DATA_W=8, din = row*16+col.
- Continuous frame, valid_in held high, 16 pixels:
  - valid_out is 0 for the first 8 output cycles, then 1 for 8 cycles;
  - at pixel (2,1) the outputs are dout1=0x01, dout2=0x11, dout3=0x21.
- Same frame with valid_in toggling 1/0:
  - output values and order are identical to the continuous frame;
  - valid_out is 0 on every cycle following a valid_in=0 cycle.
- eol/eof check:
  - eol_out pulses with (row,3) for each row;
  - eof_out pulses once, together with dout1=0x13, dout2=0x23, dout3=0x33;
  - the next frame's first 8 pixels produce valid_out=0.
- sof mid-frame:
  - stimulus: after pixel (2,2), assert sof together with valid_in and din=0xA0;
  - required: counters restart at (0,0) and no valid_out for the next 8 pixels;
  - row 2 of the new frame outputs dout1 = new row-0 data.
- Reset asserted asynchronously at pixel (3,1):
  - all outputs go to 0 without waiting for a clock edge;
  - after release, a full frame reproduces scenario 1 values from row 2 onward.
- Back-to-back frames with no idle cycles:
  - frame 2 (din += 0x80) rows 0-1 give valid_out=0;
  - row 2 gives dout1=0x80+col, dout2=0x90+col.
